// File: rtl/action_ram_acc_if.sv
// Request/response bundle for the action/value RAM. The master is the learning
// datapath that issues reads, writes and clears. The slave is the RAM.
interface action_ram_acc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  clear_start;
  logic                  busy;
  logic                  write_enable;
  logic                  write_mode;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] d_in;
  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] read_address;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  d_out_valid;
  logic                  addr_error;

  modport master (
    output clear_start, write_enable, write_mode, write_address, d_in,
           read_enable, read_address,
    input  busy, d_out, d_out_valid, addr_error
  );

  modport slave (
    input  clear_start, write_enable, write_mode, write_address, d_in,
           read_enable, read_address,
    output busy, d_out, d_out_valid, addr_error
  );
endinterface

// File: rtl/action_ram_acc.sv
// Action/value table: 1W/1R RAM with a registered read, write-first bypass,
// a signed saturating accumulate write, and a clear sweep to INIT_VALUE.
module action_ram_acc #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic             clock,
  input logic             reset_n,
  action_ram_acc_if.slave bus
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // One extra bit so that DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]   DEPTH_W    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy;
  logic                  clear_we;

  logic                  idle;
  logic                  wr_in_range, rd_in_range;
  logic                  wr_go, rd_go;
  logic                  addr_err_d;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH:0]   acc_sum;
  logic [DATA_WIDTH-1:0] wr_data;

  logic [DATA_WIDTH-1:0] d_out_q;
  logic                  d_out_valid_q;
  logic                  addr_error_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Clear-engine FSM: state register, next-state logic, outputs.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        if (cnt_q == LAST_ENTRY) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      IDLE: begin
        if (bus.clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy     = (state_q == CLEAR);
    clear_we = (state_q == CLEAR);
  end

  // ---------------------------------------------------------------------------
  // Request decode and the accumulate datapath.
  // ---------------------------------------------------------------------------
  always_comb begin
    idle        = (state_q == IDLE);
    wr_in_range = ({1'b0, bus.write_address} < DEPTH_W);
    rd_in_range = ({1'b0, bus.read_address} < DEPTH_W);
    wr_go       = idle && bus.write_enable && wr_in_range;
    rd_go       = idle && bus.read_enable && rd_in_range;
    // A single flag covers both ports, so a double miss still pulses once.
    addr_err_d  = idle && ((bus.write_enable && !wr_in_range) ||
                           (bus.read_enable  && !rd_in_range));
  end

  assign wr_old = mem[bus.write_address];

  // Sign-extend both operands by one bit. A carry into the top bit that
  // disagrees with the sign bit means the true sum does not fit.
  always_comb begin
    acc_sum = {wr_old[DATA_WIDTH-1], wr_old} + {bus.d_in[DATA_WIDTH-1], bus.d_in};
    wr_data = bus.d_in;
    if (bus.write_mode) begin
      if (acc_sum[DATA_WIDTH] != acc_sum[DATA_WIDTH-1]) begin
        wr_data = acc_sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
        wr_data = acc_sum[DATA_WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. The sweep owns the write port while busy.
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset. The clear sweep initialises it, and leaving
  // the reset off lets it map onto a RAM macro instead of DEPTH flop words.
  always_ff @(posedge clock) begin
    if (clear_we) begin
      mem[cnt_q] <= INIT_VALUE;
    end else if (wr_go) begin
      mem[bus.write_address] <= wr_data;
    end
  end

  // Registered read port with write-first bypass on address collision.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d_out_q       <= '0;
      d_out_valid_q <= 1'b0;
      addr_error_q  <= 1'b0;
    end else if (busy) begin
      d_out_valid_q <= 1'b0;
      addr_error_q  <= 1'b0;
    end else begin
      d_out_valid_q <= bus.read_enable;
      addr_error_q  <= addr_err_d;
      if (rd_go) begin
        if (wr_go && (bus.write_address == bus.read_address)) begin
          d_out_q <= wr_data;
        end else begin
          d_out_q <= mem[bus.read_address];
        end
      end else if (bus.read_enable) begin
        d_out_q <= '0;
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.d_out       = d_out_q;
  assign bus.d_out_valid = d_out_valid_q;
  assign bus.addr_error  = addr_error_q;

endmodule

// File: tb/tb_action_ram_acc.sv
// Scoreboard bench for action_ram_acc: a full-depth instance (256) and a
// short instance (200) for out-of-range addressing, both on one clock/reset.
module tb_action_ram_acc;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clock;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;

  exp_t dq0[$];
  exp_t dq1[$];
  int   eq0[$];
  int   eq1[$];

  action_ram_acc_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus0 ();
  action_ram_acc_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus1 ();

  action_ram_acc #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(256)) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  action_ram_acc #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(200)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation per d_out_valid / addr_error pulse.
  always @(negedge clock) begin
    exp_t e;
    int   d;
    if (bus0.d_out_valid) begin
      if (dq0.size() == 0) check("dut0 spurious d_out_valid", 32'(bus0.d_out_valid), 0);
      else begin
        e = dq0.pop_front();
        check("dut0 d_out", 32'(bus0.d_out), 32'(e.data));
        check("dut0 read latency", cyc, e.due);
      end
    end
    if (bus0.addr_error) begin
      if (eq0.size() == 0) check("dut0 spurious addr_error", 32'(bus0.addr_error), 0);
      else begin
        d = eq0.pop_front();
        check("dut0 addr_error cycle", cyc, d);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    int   d;
    if (bus1.d_out_valid) begin
      if (dq1.size() == 0) check("dut1 spurious d_out_valid", 32'(bus1.d_out_valid), 0);
      else begin
        e = dq1.pop_front();
        check("dut1 d_out", 32'(bus1.d_out), 32'(e.data));
        check("dut1 read latency", cyc, e.due);
      end
    end
    if (bus1.addr_error) begin
      if (eq1.size() == 0) check("dut1 spurious addr_error", 32'(bus1.addr_error), 0);
      else begin
        d = eq1.pop_front();
        check("dut1 addr_error cycle", cyc, d);
      end
    end
  end

  task automatic idle_all();
    bus0.write_enable = 1'b0; bus0.read_enable = 1'b0; bus0.clear_start = 1'b0;
    bus1.write_enable = 1'b0; bus1.read_enable = 1'b0; bus1.clear_start = 1'b0;
  endtask

  task automatic idle();
    @(negedge clock);
    idle_all();
  endtask

  // One request cycle on the selected instance. The expected read data is
  // supplied by the caller, and the response is due one edge later.
  task automatic drive(input bit sel, input bit we, input bit wm, input logic [7:0] wa,
                       input logic [15:0] d, input bit re, input logic [7:0] ra,
                       input logic [15:0] exp);
    exp_t e;
    int   depth;
    @(negedge clock);
    idle_all();
    depth = sel ? 200 : 256;
    if (sel) begin
      bus1.write_enable = we; bus1.write_mode = wm; bus1.write_address = wa;
      bus1.d_in = d; bus1.read_enable = re; bus1.read_address = ra;
    end else begin
      bus0.write_enable = we; bus0.write_mode = wm; bus0.write_address = wa;
      bus0.d_in = d; bus0.read_enable = re; bus0.read_address = ra;
    end
    e.data = exp;
    e.due  = cyc + 1;
    if (re) begin
      if (sel) dq1.push_back(e); else dq0.push_back(e);
    end
    if ((we && int'(wa) >= depth) || (re && int'(ra) >= depth)) begin
      if (sel) eq1.push_back(cyc + 1); else eq0.push_back(cyc + 1);
    end
  endtask

  task automatic wait_idle(input bit sel, output int fall_cyc);
    fall_cyc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clock);
      #1;
      if (!(sel ? bus1.busy : bus0.busy)) begin
        fall_cyc = cyc;
        return;
      end
    end
  endtask

  task automatic rd(input bit sel, input logic [7:0] a, input logic [15:0] exp);
    drive(sel, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, a, exp);
  endtask

  task automatic wr(input bit sel, input bit wm, input logic [7:0] a, input logic [15:0] d);
    drive(sel, 1'b1, wm, a, d, 1'b0, 8'h00, 16'h0000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, c0, f0, f1;
    checks = 0;
    errors = 0;
    reset_n = 1'b1;
    bus0.write_mode = 1'b0; bus0.write_address = '0; bus0.d_in = '0; bus0.read_address = '0;
    bus1.write_mode = 1'b0; bus1.write_address = '0; bus1.d_in = '0; bus1.read_address = '0;
    idle_all();

    // Reset state.
    #1 reset_n = 1'b0;
    #1;
    check("reset d_out", 32'(bus0.d_out), 0);
    check("reset d_out_valid", 32'(bus0.d_out_valid), 0);
    check("reset addr_error", 32'(bus0.addr_error), 0);
    check("reset busy dut0", 32'(bus0.busy), 1);
    check("reset busy dut1", 32'(bus1.busy), 1);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    r0 = cyc;
    fork
      wait_idle(1'b0, f0);
      wait_idle(1'b1, f1);
    join
    check("initial sweep length dut0", f0 - r0, 256);
    check("initial sweep length dut1", f1 - r0, 200);

    // Swept entries read as zero.
    rd(0, 8'h00, 16'h0000);
    rd(0, 8'h7F, 16'h0000);
    rd(0, 8'hFF, 16'h0000);

    // Overwrite, then read back one per cycle.
    for (int i = 0; i < 6; i++) wr(0, 1'b0, 8'(8'h20 + i), 16'(i + 2));
    for (int i = 0; i < 6; i++) rd(0, 8'(8'h20 + i), 16'(i + 2));

    // Saturating accumulate: positive clamp, negative clamp, plain adds.
    wr(0, 1'b0, 8'h10, 16'h7FF0);
    wr(0, 1'b0, 8'h11, 16'h8000);
    wr(0, 1'b0, 8'h12, 16'h0005);
    wr(0, 1'b0, 8'h13, 16'h0005);
    wr(0, 1'b1, 8'h10, 16'h0020);
    wr(0, 1'b1, 8'h11, 16'hFFFF);
    wr(0, 1'b1, 8'h12, 16'hFFFD);
    wr(0, 1'b1, 8'h13, 16'h0003);
    rd(0, 8'h10, 16'h7FFF);
    rd(0, 8'h11, 16'h8000);
    rd(0, 8'h12, 16'h0002);
    rd(0, 8'h13, 16'h0008);

    // Same-address collisions are write-first, including the saturated result.
    wr(0, 1'b0, 8'h30, 16'h0009);
    drive(0, 1'b1, 1'b1, 8'h30, 16'h0001, 1'b1, 8'h30, 16'h000A);
    rd(0, 8'h30, 16'h000A);
    drive(0, 1'b1, 1'b0, 8'h31, 16'h1234, 1'b1, 8'h31, 16'h1234);
    drive(0, 1'b1, 1'b1, 8'h10, 16'h0001, 1'b1, 8'h10, 16'h7FFF);
    // Different addresses in one cycle are independent.
    drive(0, 1'b1, 1'b0, 8'h40, 16'h0055, 1'b1, 8'h20, 16'h0002);
    rd(0, 8'h40, 16'h0055);
    idle();

    // Out-of-range on the 200-entry instance.
    wr(1, 1'b0, 8'h05, 16'h0077);
    drive(1, 1'b1, 1'b0, 8'hF0, 16'hABCD, 1'b1, 8'hF0, 16'h0000);
    rd(1, 8'h05, 16'h0077);
    drive(1, 1'b1, 1'b0, 8'hC8, 16'hBEEF, 1'b1, 8'hC7, 16'h0000);
    rd(1, 8'hC8, 16'h0000);
    rd(1, 8'h70, 16'h0000);
    rd(1, 8'h48, 16'h0000);
    idle();

    // Requested clear: stray traffic and clear_start during the sweep are ignored.
    wr(0, 1'b0, 8'h50, 16'h1111);
    rd(0, 8'h50, 16'h1111);
    @(negedge clock);
    idle_all();
    bus0.clear_start = 1'b1;
    @(posedge clock);
    #1;
    check("busy after clear_start", 32'(bus0.busy), 1);
    c0 = cyc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      bus0.write_enable = 1'b1; bus0.write_mode = 1'b0;
      bus0.write_address = 8'h60; bus0.d_in = 16'h2222;
      bus0.read_enable = 1'b1; bus0.read_address = 8'h50;
    end
    idle();
    check("d_out holds during clear", 32'(bus0.d_out), 32'h1111);
    wait_idle(1'b0, f0);
    check("requested sweep length", f0 - c0, 256);
    rd(0, 8'h50, 16'h0000);
    rd(0, 8'h60, 16'h0000);
    rd(0, 8'h20, 16'h0000);
    rd(0, 8'h10, 16'h0000);

    // Reset at counter 100 restarts the sweep from entry 0.
    wr(0, 1'b0, 8'h70, 16'h3333);
    rd(0, 8'h70, 16'h3333);
    @(negedge clock);
    idle_all();
    bus0.clear_start = 1'b1;
    @(posedge clock);
    #1;
    c0 = cyc;
    @(negedge clock);
    bus0.clear_start = 1'b0;
    for (int i = 0; i < 200 && cyc < c0 + 100; i++) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid-sweep reset busy", 32'(bus0.busy), 1);
    check("mid-sweep reset d_out", 32'(bus0.d_out), 0);
    @(negedge clock);
    reset_n = 1'b1;
    r0 = cyc;
    fork
      wait_idle(1'b0, f0);
      wait_idle(1'b1, f1);
    join
    check("restarted sweep length dut0", f0 - r0, 256);
    check("restarted sweep length dut1", f1 - r0, 200);
    rd(0, 8'h70, 16'h0000);
    rd(0, 8'hFF, 16'h0000);
    rd(0, 8'h00, 16'h0000);
    rd(1, 8'h05, 16'h0000);
    idle();
    repeat (3) @(negedge clock);

    check("dut0 responses outstanding", dq0.size(), 0);
    check("dut1 responses outstanding", dq1.size(), 0);
    check("dut0 addr_error outstanding", eq0.size(), 0);
    check("dut1 addr_error outstanding", eq1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/action_ram_acc.md
Name: action_ram_acc

Overview:
- Parametrised successor of the action RAM: a dual-port (1 write, 1 read) action/value table for the tic-tac-toe learning datapath.
- Adds a registered read with a valid flag, and a write-first bypass for same-address read/write.
- Adds a signed saturating accumulate write mode, used for value updates.
- Adds a clear engine that sweeps every entry to INIT_VALUE after reset or on request.

Parameters:
DATA_WIDTH, 16, entry width in bits (signed two's complement)
ADDR_WIDTH, 8, address width
DEPTH, 256, number of entries (must be <= 2**ADDR_WIDTH)
INIT_VALUE, 0, value written to every entry by the clear sweep

Ports:
clock  in  1  system clock; all state changes on its rising edge
reset_n  in  1  asynchronous active-low reset
clear_start  in  1  request a full clear sweep; sampled only in IDLE
busy  out  1  high while the clear sweep runs
write_enable  in  1  write request
write_mode  in  1  0 = overwrite, 1 = saturating accumulate
write_address  in  ADDR_WIDTH  write address
d_in  in  DATA_WIDTH  write data, or the signed addend in accumulate mode
read_enable  in  1  read request
read_address  in  ADDR_WIDTH  read address
d_out  out  DATA_WIDTH  registered read data
d_out_valid  out  1  one-cycle pulse marking new d_out
addr_error  out  1  one-cycle pulse: an accepted request had an address >= DEPTH

Behaviour:
- Reset: async assert of reset_n gives d_out=0, d_out_valid=0, addr_error=0, busy=1, state=CLEAR, clear counter=0. Memory contents are not reset; the sweep initialises them.
- FSM states:
  - CLEAR: writes INIT_VALUE to mem[counter] each cycle and increments counter. On the edge that writes DEPTH-1, state goes to IDLE; busy falls in that same edge. A full sweep takes exactly DEPTH cycles.
  - IDLE: clear_start=1 sets busy=1, counter=0, state=CLEAR on the next edge. clear_start is ignored in CLEAR; a sweep always runs to completion.
  - Reset asserted mid-sweep restarts the sweep from entry 0.
- While busy=1: write_enable and read_enable are ignored; d_out holds its value; d_out_valid=0; addr_error=0.
- Write (IDLE, write_enable=1, write_address<DEPTH), committed at the edge:
  - write_mode=0: mem[a] <= d_in.
  - write_mode=1: mem[a] <= sat(mem[a] + d_in), signed add at DATA_WIDTH+1 bits, clamped to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1].
- Read (IDLE, read_enable=1, read_address<DEPTH): at the edge, d_out <= mem[r] and d_out_valid <= 1. Latency is 1 cycle. With no read, d_out holds and d_out_valid <= 0.
- Same-address read and write in one cycle is write-first: d_out gets the newly written value, including the saturated accumulate result.
- Out-of-range address (>= DEPTH), read or write: no memory change. A read gives d_out <= 0 and d_out_valid <= 1. addr_error <= 1 for one cycle; it is asserted once even if both ports are out of range.
- Read and write to different addresses in one cycle are independent. There is no backpressure.

Test Plan:
- Reset then idle: busy=1 for exactly 256 cycles after reset_n rises, then 0. Reading 0x00, 0x7F and 0xFF returns 0 with d_out_valid pulsing one cycle after each read_enable.
- Overwrite: write 0x20..0x25 with data 2..7 (write_mode=0), then read 0x20..0x25 one per cycle -> d_out 2..7, each one cycle after its request.
- Accumulate: mem[0x10]=0x7FF0 plus d_in 0x0020 -> 0x7FFF. mem[0x11]=0x8000 plus d_in 0xFFFF -> 0x8000. mem[0x12]=5 plus d_in 0xFFFD -> 2.
- Collision: mem[0x30]=9; in the same cycle, accumulate d_in 1 to 0x30 and read 0x30 -> d_out=10 next cycle, and mem[0x30]=10 on a later read.
- Out of range (DEPTH=200 build): write 0xF0 and read 0xF0 -> addr_error pulses once, d_out=0 with d_out_valid=1, and no entry changes.
- Clear and reset interplay: clear_start in IDLE -> busy for DEPTH cycles, all entries = INIT_VALUE, reads and writes during busy ignored. Pulse reset_n low at counter=100 -> sweep restarts and busy lasts a full DEPTH cycles.
